// File: rtl/scan_timebase.sv
// scan_timebase: clock prescaler plus scan channel index generator for LED / 7-segment multiplexing.
// Ports:
//   i_clk, i_rst_n   system clock (rising edge), asynchronous active-low reset
//   i_en             count enable; everything holds while low
//   i_clr            synchronous clear back to the reset state; beats i_en
//   i_mode           00 up-wrap, 01 down-wrap, 10 ping-pong, 11 single sweep
//   o_counter        prescaler value, 0..CLK_DIV-1
//   o_tick           one-cycle pulse on each prescaler wrap (channel step)
//   o_ch             channel index, 0..N_CH-1
//   o_wrap           one-cycle pulse on a sequence boundary
//   o_done           sticky flag once a single sweep has completed
module scan_timebase #(
    parameter int CLK_DIV = 10000,
    parameter int N_CH = 20,
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [1:0]       i_mode,
    output logic [CNT_W-1:0] o_counter,
    output logic             o_tick,
    output logic [CH_W-1:0]  o_ch,
    output logic             o_wrap,
    output logic             o_done
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CH_W-1:0] CH_MAX = CH_W'(N_CH - 1);
    // Ping-pong turnaround target when bouncing off the top end
    localparam logic [CH_W-1:0] CH_PEN = CH_W'((N_CH > 1) ? N_CH - 2 : 0);
    logic [CNT_W-1:0] cnt;
    logic [CH_W-1:0] ch, ch_nxt, up_nxt, dn_nxt, pp_nxt, sw_nxt;
    logic dir_dn, dir_nxt, pp_turn, wrap_nxt, done_nxt, tick, wrap, done, at_max;
    always_comb begin
        at_max = (cnt == CNT_MAX);
        up_nxt = (ch == CH_MAX) ? '0 : ch + CH_W'(1);
        dn_nxt = (ch == '0) ? CH_MAX : ch - CH_W'(1);
        pp_turn = dir_dn ? (ch == '0) : (ch == CH_MAX);
        // With a single channel there is nowhere to bounce to, so stay at 0
        pp_nxt = (N_CH == 1) ? '0 :
                 pp_turn ? (dir_dn ? CH_W'(1) : CH_PEN) :
                 (dir_dn ? ch - CH_W'(1) : ch + CH_W'(1));
        // Saturating step keeps the index in range if the mode is switched at the top
        sw_nxt = (ch == CH_MAX) ? CH_MAX : ch + CH_W'(1);
        ch_nxt = i_mode[1] ? (i_mode[0] ? sw_nxt : pp_nxt) : (i_mode[0] ? dn_nxt : up_nxt);
        dir_nxt = (i_mode == 2'b10 && pp_turn) ? ~dir_dn : dir_dn;
        // Up-type sequences end on 0, down-wrap and sweep end on the top channel
        wrap_nxt = i_mode[0] ? (ch_nxt == CH_MAX) : (ch_nxt == '0);
        done_nxt = (i_mode == 2'b11) && (ch_nxt == CH_MAX);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
            ch <= '0;
            dir_dn <= 1'b0;
            tick <= 1'b0;
            wrap <= 1'b0;
            done <= 1'b0;
        end else if (i_clr) begin
            cnt <= '0;
            ch <= '0;
            dir_dn <= 1'b0;
            tick <= 1'b0;
            wrap <= 1'b0;
            done <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (i_en && !done) begin
                cnt <= at_max ? '0 : cnt + CNT_W'(1);
                if (at_max) begin
                    ch <= ch_nxt;
                    dir_dn <= dir_nxt;
                    tick <= 1'b1;
                    wrap <= wrap_nxt;
                    done <= done_nxt;
                end
            end
        end
    end
    assign o_counter = cnt;
    assign o_ch = ch;
    assign o_tick = tick;
    assign o_wrap = wrap;
    assign o_done = done;
endmodule

// File: tb/tb_scan_timebase.sv
// tb_scan_timebase: directed self-checking bench for scan_timebase (CLK_DIV=4/N_CH=3 and CLK_DIV=1/N_CH=1).
module tb_scan_timebase;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] counter;
    logic [1:0] ch;
    logic tick, wrap, done;
    logic counter1, ch1, tick1, wrap1, done1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_timebase #(.CLK_DIV(4), .N_CH(3)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_mode(mode),
        .o_counter(counter), .o_tick(tick), .o_ch(ch), .o_wrap(wrap), .o_done(done)
    );

    scan_timebase #(.CLK_DIV(1), .N_CH(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_mode(mode),
        .o_counter(counter1), .o_tick(tick1), .o_ch(ch1), .o_wrap(wrap1), .o_done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".counter"}, 32'(counter), 0);
        chk({tag, ".tick"}, 32'(tick), 0);
        chk({tag, ".ch"}, 32'(ch), 0);
        chk({tag, ".wrap"}, 32'(wrap), 0);
        chk({tag, ".done"}, 32'(done), 0);
    endtask

    // From counter==0: three quiet cycles, then the tick cycle carrying the new channel
    task automatic run_step(input string tag, input int exp_ch, input int exp_wrap, input int exp_done);
        repeat (3) step();
        chk({tag, ".pre_tick"}, 32'(tick), 0);
        step();
        chk({tag, ".tick"}, 32'(tick), 1);
        chk({tag, ".ch"}, 32'(ch), 32'(exp_ch));
        chk({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
        chk({tag, ".done"}, 32'(done), 32'(exp_done));
        chk({tag, ".counter"}, 32'(counter), 0);
    endtask

    int pp_exp[10] = '{1, 2, 1, 0, 1, 2, 1, 0, 1, 2};
    int dn_exp[4] = '{2, 1, 0, 2};

    initial begin
        step();
        chk_zero("reset");
        chk("reset.counter1", 32'(counter1), 0);
        chk("reset.done1", 32'(done1), 0);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (6) step();
        chk("mid.counter", 32'(counter), 2);
        chk("mid.ch", 32'(ch), 1);
        #3 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        en = 1'b0;
        step();
        rst_n = 1'b1;
        en = 1'b1;
        mode = 2'b00;
        for (int k = 1; k <= 24; k++) begin
            step();
            chk("up.counter", 32'(counter), 32'(k % 4));
            chk("up.tick", 32'(tick), 32'(k % 4 == 0));
            chk("up.ch", 32'(ch), 32'((k / 4) % 3));
            chk("up.wrap", 32'(wrap), 32'(k % 4 == 0 && (k / 4) % 3 == 0));
        end
        clr = 1'b1;
        mode = 2'b10;
        step();
        chk_zero("clr_pp");
        clr = 1'b0;
        for (int i = 0; i < 10; i++) run_step("pingpong", pp_exp[i], int'(pp_exp[i] == 0), 0);
        clr = 1'b1;
        mode = 2'b01;
        step();
        chk_zero("clr_dn");
        clr = 1'b0;
        for (int i = 0; i < 4; i++) run_step("down", dn_exp[i], int'(dn_exp[i] == 2), 0);
        clr = 1'b1;
        mode = 2'b11;
        step();
        chk_zero("clr_sweep");
        clr = 1'b0;
        run_step("sweep1", 1, 0, 0);
        run_step("sweep2", 2, 1, 1);
        repeat (20) step();
        chk("frozen.counter", 32'(counter), 0);
        chk("frozen.tick", 32'(tick), 0);
        chk("frozen.wrap", 32'(wrap), 0);
        chk("frozen.ch", 32'(ch), 2);
        chk("frozen.done", 32'(done), 1);
        clr = 1'b1;
        step();
        chk_zero("clr_done");
        clr = 1'b0;
        step();
        chk("resume.counter", 32'(counter), 1);
        step();
        chk("resume.counter2", 32'(counter), 2);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold.counter", 32'(counter), 2);
            chk("hold.tick", 32'(tick), 0);
        end
        clr = 1'b1;
        en = 1'b1;
        step();
        chk_zero("clr_over_en");
        mode = 2'b00;
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("div1.tick", 32'(tick1), 1);
            chk("div1.wrap", 32'(wrap1), 1);
            chk("div1.counter", 32'(counter1), 0);
            chk("div1.ch", 32'(ch1), 0);
        end
        clr = 1'b1;
        mode = 2'b11;
        step();
        clr = 1'b0;
        step();
        chk("div1_sweep.done", 32'(done1), 1);
        chk("div1_sweep.wrap", 32'(wrap1), 1);
        step();
        chk("div1_sweep.frozen_tick", 32'(tick1), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
